// File: rtl/fetch_defs.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encodings
// and default widths.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_ADVANCE = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_DATA_SIZE      = 16;
  localparam int DEFAULT_ADDR_SIZE      = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/fetch_timer.sv
// FETCH-state watchdog: counts enabled cycles and flags the last allowed one.
// The count saturates at the limit, so it never wraps.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Combinational so the FSM leaves FETCH at the end of cycle TIMEOUT_CYCLES.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC -> ROM request/ack -> instruction register ->
// valid/ready to the core -> PC inc/load. Optional fetch watchdog: FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_defs::*;
#(
  parameter int DATA_SIZE      = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE      = DEFAULT_ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] pc_value,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic [ADDR_SIZE-1:0] pc_target,
  output logic                 rom_req,
  output logic [ADDR_SIZE-1:0] rom_addr,
  input  logic                 rom_ack,
  input  logic [DATA_SIZE-1:0] rom_data,
  output logic [DATA_SIZE-1:0] instr_out,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 jump_req,
  input  logic [ADDR_SIZE-1:0] jump_addr,
  output logic                 busy,
`ifdef FETCH_TIMEOUT_EN
  output logic                 fetch_err,
`endif
  output logic [1:0]           state_dbg
);

  // Handshake: an instruction transfers to the core in the cycle where
  // instr_valid and instr_ready are both high; instr_valid stays high and
  // instr_out stays stable until then.

  fetch_state_t state, next_state;
  logic [DATA_SIZE-1:0] instr_q;
  logic                 jump_q;
  logic [ADDR_SIZE-1:0] jump_addr_q;
  logic                 timeout_expired;
  logic                 halted;

`ifdef FETCH_TIMEOUT_EN
  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (state == ST_FETCH),
    .clear  (state != ST_FETCH),
    .expired(timeout_expired)
  );

  // Sticky until reset; a same-cycle ack wins over the timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (state == ST_FETCH && timeout_expired && !rom_ack) begin
      fetch_err <= 1'b1;
    end
  end

  assign halted = fetch_err;
`else
  assign timeout_expired = 1'b0;
  assign halted          = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH && rom_ack) begin
        instr_q <= rom_data;
      end
      if (state == ST_HOLD && instr_ready) begin
        jump_q      <= jump_req;
        jump_addr_q <= jump_addr;
      end
    end
  end

  always_comb begin
    next_state  = state;
    rom_req     = 1'b0;
    rom_addr    = '0;
    instr_valid = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_target   = '0;
    case (state)
      ST_IDLE: begin
        if (!halted) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        rom_req  = 1'b1;
        rom_addr = pc_value;
        if (rom_ack) begin
          next_state = ST_HOLD;
        end else if (timeout_expired) begin
          next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) next_state = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (jump_q) begin
          pc_load   = 1'b1;
          pc_target = jump_addr_q;
        end else begin
          pc_inc = 1'b1;
        end
        next_state = ST_FETCH;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign instr_out = instr_q;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a PC model, a wait-state ROM model
// and an instruction scoreboard. Define FETCH_TIMEOUT_EN to cover the watchdog.
module tb_fetch_sequencer;
  import fetch_defs::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] pc_value, pc_target, rom_addr, jump_addr;
  logic          pc_load, pc_inc, rom_req, rom_ack;
  logic [DW-1:0] rom_data, instr_out;
  logic          instr_valid, instr_ready, jump_req, busy;
  logic [1:0]    state_dbg;
`ifdef FETCH_TIMEOUT_EN
  logic          fetch_err;
`endif

  fetch_sequencer #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .pc_value(pc_value),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_target(pc_target),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_req(jump_req), .jump_addr(jump_addr), .busy(busy),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err(fetch_err),
`endif
    .state_dbg(state_dbg)
  );

  // Environment: program counter and a ROM answering after rom_wait cycles
  logic [AW-1:0] pc_model;
  int            rom_wait;
  int            wait_cnt;
  logic          ack_en;
  logic          ack_force;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a ^ 16'h1234;
  endfunction

  assign pc_value = pc_model;
  assign rom_data = rom_word(rom_addr);
  assign rom_ack  = ack_force | (ack_en & rom_req & (wait_cnt >= rom_wait));

  always @(posedge clock) begin
    if (reset)        pc_model <= '0;
    else if (pc_load) pc_model <= pc_target;
    else if (pc_inc)  pc_model <= pc_model + 16'd1;
    if (!rom_req || rom_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rom_req"}, rom_req, 0);
    check_val({tag, "_valid"}, instr_valid, 0);
    check_val({tag, "_pc_load"}, pc_load, 0);
    check_val({tag, "_pc_inc"}, pc_inc, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // One full instruction; entered in the first FETCH cycle, leaves in the next one.
  task automatic run_instr(input int waits, input int stall, input logic jmp,
                           input logic [AW-1:0] jaddr);
    logic [DW-1:0] prev;
    prev     = instr_out;
    rom_wait = waits;
    ack_en   = 1'b1;
    for (int c = 0; c <= waits; c++) begin
      check_val("fetch_req", rom_req, 1);
      check_val("fetch_addr", rom_addr, exp_pc);
      check_val("fetch_instr_held", instr_out, prev);
      check_val("fetch_valid", instr_valid, 0);
      if (c == waits) exp_q.push_back(rom_word(exp_pc));
      tick();
    end
    ack_en = 1'b0;
    for (int c = 0; c < stall; c++) begin
      check_val("hold_valid", instr_valid, 1);
      check_val("hold_req", rom_req, 0);
      if (exp_q.size() > 0) check_val("hold_instr", instr_out, exp_q[0]);
      jump_req  = (c == stall / 2);
      jump_addr = 16'hdead ^ AW'(c);
      tick();
    end
    instr_ready = 1'b1;
    jump_req    = jmp;
    jump_addr   = jaddr;
    check_val("accept_valid", instr_valid, 1);
    if (exp_q.size() == 0) check_val("sb_empty", 0, 1);
    else                   check_val("accept_instr", instr_out, exp_q.pop_front());
    tick();
    instr_ready = 1'b0;
    jump_req    = 1'b0;
    jump_addr   = AW'($urandom_range(0, 16'hffff));
    check_val("adv_state", state_dbg, ST_ADVANCE);
    check_val("adv_load", pc_load, jmp);
    check_val("adv_inc", pc_inc, !jmp);
    check_val("adv_target", pc_target, jmp ? jaddr : '0);
    check_val("adv_valid", instr_valid, 0);
    exp_pc = jmp ? jaddr : exp_pc + 16'd1;
    tick();
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b0; jump_req = 1'b0; jump_addr = '0;
    ack_en = 1'b0; ack_force = 1'b0; rom_wait = 0;
    repeat (3) tick();
    check_idle("reset");
    check_val("reset_instr", instr_out, 0);
    reset = 1'b0;
    tick();
    exp_pc = '0;

    run_instr(0, 0, 1'b0, '0);          // zero-wait, ROM[0]=0x1234
    run_instr(3, 0, 1'b0, '0);          // 3 wait states
    run_instr(0, 0, 1'b1, 16'h0100);    // jump
    run_instr(1, 5, 1'b0, '0);          // stalled core, stray jump pulse
    run_instr(0, 0, 1'b1, 16'hffff);
    run_instr(2, 0, 1'b0, '0);          // wrap 0xFFFF -> 0x0000
    run_instr(0, 1, 1'b1, exp_pc);      // jump to the current address
    run_instr(0, 0, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 16'hffff)));
    end

    // reset in FETCH, ack arriving after the reset edge
    ack_en = 1'b0;
    tick();
    check_val("pre_reset_req", rom_req, 1);
    reset = 1'b1;
    tick();
    check_idle("mid_reset");
    check_val("mid_reset_instr", instr_out, 0);
    ack_force = 1'b1;
    tick();
    check_idle("reset_ack");
    reset = 1'b0;
    tick();
    ack_force = 1'b0;
    check_val("late_ack_instr", instr_out, 0);
    check_val("late_ack_valid", instr_valid, 0);
    check_val("late_ack_state", state_dbg, ST_FETCH);
    exp_pc = '0;
    run_instr(0, 0, 1'b0, '0);

`ifdef FETCH_TIMEOUT_EN
    ack_en = 1'b0;
    for (int c = 0; c < TO; c++) begin
      check_val("to_req", rom_req, 1);
      check_val("to_err_low", fetch_err, 0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      check_val("to_err", fetch_err, 1);
      check_idle("to_idle");
      tick();
    end
    reset = 1'b1;
    tick();
    check_val("to_err_clear", fetch_err, 0);
    reset = 1'b0;
    tick();
`else
    ack_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_val("wait_req", rom_req, 1);
      check_val("wait_addr", rom_addr, exp_pc);
      tick();
    end
`endif
    run_instr(0, 0, 1'b0, '0);

    if (exp_q.size() != 0) check_val("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
